// File: rtl/tone_sample_gen.sv
// Stereo square-wave tone source with a shared click-free volume envelope.
// Produces {left, right} signed 16-bit samples, refreshed once per sample period.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | env held at 0, waiting for play with a non-zero volume
//   RAMP_UP   | env climbs by STEP per sample toward the target amplitude
//   HOLD      | env equals the target amplitude
//   RAMP_DOWN | env falls by STEP per sample toward the target amplitude
module tone_sample_gen #(
  parameter int          SAMPLE_DIV = 512,
  parameter logic [15:0] STEP       = 16'h0100,
  parameter int          DIV_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] note_div_left,
  input  logic [DIV_W-1:0] note_div_right,
  input  logic [2:0]       vol,
  input  logic             play,
  output logic [31:0]      audio_out,
  output logic             sample_tick,
  output logic [1:0]       env_state
);

  localparam int SCNT_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    HOLD      = 2'b10,
    RAMP_DOWN = 2'b11
  } env_state_t;

  logic [SCNT_W-1:0] smp_cnt_q;
  logic [DIV_W-1:0]  div_w   [2];
  logic [DIV_W-1:0]  cnt_q   [2];
  logic              phase_q [2];
  logic [15:0]       ch      [2];
  env_state_t        state_q, state_d;
  logic [15:0]       env_q, env_d;
  logic [15:0]       tgt;
  logic [31:0]       audio_q;

  // index 0 is the left channel, index 1 the right channel
  assign div_w[0]    = note_div_left;
  assign div_w[1]    = note_div_right;
  assign sample_tick = (smp_cnt_q == SCNT_W'(SAMPLE_DIV - 1));
  assign tgt         = play ? {1'b0, vol, 12'h000} : 16'h0000;
  assign audio_out   = audio_q;
  assign env_state   = state_q;

  // free-running sample-period counter; wraps on its own at SAMPLE_DIV
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) smp_cnt_q <= '0;
    else      smp_cnt_q <= smp_cnt_q + SCNT_W'(1);
  end

  // per-channel pitch dividers; >= lets a freshly shortened period wrap at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= '0;
        phase_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (div_w[i] == '0) begin
          cnt_q[i]   <= '0;
          phase_q[i] <= 1'b0;
        end else if (cnt_q[i] >= div_w[i] - DIV_W'(1)) begin
          cnt_q[i]   <= '0;
          phase_q[i] <= ~phase_q[i];
        end else begin
          cnt_q[i]   <= cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // envelope next-state and amplitude, advanced only on the sample tick
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          env_d = 16'h0000;
          if (play && tgt != 16'h0000) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (tgt < env_q) begin
            state_d = RAMP_DOWN;
          end else if (tgt - env_q > STEP) begin
            env_d = env_q + STEP;
          end else begin
            env_d   = tgt;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (tgt > env_q)      state_d = RAMP_UP;
          else if (tgt < env_q) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (tgt > env_q) begin
            state_d = RAMP_UP;
          end else if (env_q - tgt > STEP) begin
            env_d = env_q - STEP;
          end else begin
            env_d   = tgt;
            state_d = (tgt == 16'h0000) ? IDLE : HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          env_d   = 16'h0000;
        end
      endcase
    end
  end

  // envelope state and amplitude registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      env_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // channel samples use the updated env and the phase before any same-cycle toggle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ch[i] = 16'h0000;
      if (div_w[i] != '0) ch[i] = phase_q[i] ? env_d : (16'h0000 - env_d);
    end
  end

  // output word changes only on the tick so the transmitter sees a stable value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             audio_q <= 32'h0;
    else if (sample_tick) audio_q <= {ch[0], ch[1]};
  end

endmodule

// File: tb/tb_tone_sample_gen.sv
// Directed bench for tone_sample_gen: envelope walk through a vector table,
// then async reset mid-ramp and a divider shrink / right-channel mute sequence.
module tb_tone_sample_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] ndl, ndr;
  logic [2:0]  vol;
  logic        play;
  logic [31:0] audio;
  logic        tick;
  logic [1:0]  est;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;

  always #5 clk = ~clk;

  tone_sample_gen dut (
    .clk           (clk),
    .rst           (rst),
    .note_div_left (ndl),
    .note_div_right(ndr),
    .vol           (vol),
    .play          (play),
    .audio_out     (audio),
    .sample_tick   (tick),
    .env_state     (est)
  );

  typedef struct {
    logic        play;
    logic [2:0]  vol;
    int          tick;
    logic [1:0]  st;
    logic [31:0] aud;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // waits for the next tick (bounded), then steps one more negedge so the
  // registered outputs of that tick are visible
  task automatic tick_wait(input int exp_cyc);
    int          cyc;
    logic [31:0] held;
    cyc  = 0;
    held = audio;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < 1000);
    chk("tick_period", cyc, exp_cyc);
    chk("audio_hold", audio, held);
    ticks++;
    @(negedge clk);
    chk("tick_width", {31'b0, tick}, 32'h0);
  endtask

  initial begin
    // divL=1024, divR=512 from reset: left phase at tick m = ((m-1)/2)%2,
    // right phase at tick m = (m-1)%2; phase 0 gives -env
    vecs[0]  = '{1'b0, 3'd2,  1, 2'b00, 32'h0000_0000};
    vecs[1]  = '{1'b1, 3'd2,  2, 2'b01, 32'h0000_0000};
    vecs[2]  = '{1'b1, 3'd2,  3, 2'b01, 32'h0100_FF00};
    vecs[3]  = '{1'b1, 3'd2, 33, 2'b01, 32'hE100_E100};
    vecs[4]  = '{1'b1, 3'd2, 34, 2'b10, 32'hE000_2000};
    vecs[5]  = '{1'b1, 3'd2, 35, 2'b10, 32'h2000_E000};
    vecs[6]  = '{1'b1, 3'd1, 36, 2'b11, 32'h2000_2000};
    vecs[7]  = '{1'b1, 3'd1, 51, 2'b11, 32'h1100_EF00};
    vecs[8]  = '{1'b1, 3'd1, 52, 2'b10, 32'h1000_1000};
    vecs[9]  = '{1'b1, 3'd2, 53, 2'b01, 32'hF000_F000};
    vecs[10] = '{1'b1, 3'd2, 56, 2'b01, 32'h1300_1300};
    vecs[11] = '{1'b0, 3'd2, 57, 2'b11, 32'hED00_ED00};
    vecs[12] = '{1'b0, 3'd2, 60, 2'b11, 32'h1000_1000};
    vecs[13] = '{1'b1, 3'd2, 61, 2'b01, 32'hF000_F000};
    vecs[14] = '{1'b0, 3'd2, 62, 2'b11, 32'hF000_1000};
    vecs[15] = '{1'b0, 3'd2, 77, 2'b11, 32'hFF00_FF00};
    vecs[16] = '{1'b0, 3'd2, 78, 2'b00, 32'h0000_0000};
    vecs[17] = '{1'b1, 3'd0, 79, 2'b00, 32'h0000_0000};
    vecs[18] = '{1'b0, 3'd7, 80, 2'b00, 32'h0000_0000};

    rst  = 1'b1;
    play = 1'b0;
    vol  = 3'd2;
    ndl  = 22'd1024;
    ndr  = 22'd512;
    #2 rst = 1'b0;
    #10;
    chk("reset_audio", audio, 32'h0);
    chk("reset_state", {30'b0, est}, 32'h0);
    chk("reset_tick",  {31'b0, tick}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      play = vecs[i].play;
      vol  = vecs[i].vol;
      while (ticks < vecs[i].tick) tick_wait(511);
      chk($sformatf("vec%0d_state", i), {30'b0, est}, {30'b0, vecs[i].st});
      chk($sformatf("vec%0d_audio", i), audio, vecs[i].aud);
    end

    // climb to env=0x300 then pull reset between clock edges
    play = 1'b1;
    vol  = 3'd1;
    repeat (4) tick_wait(511);
    chk("preRst_state", {30'b0, est}, 32'h1);
    chk("preRst_audio", audio, 32'h0300_0300);
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("asyncRst_audio", audio, 32'h0);
    chk("asyncRst_state", {30'b0, est}, 32'h0);
    chk("asyncRst_tick",  {31'b0, tick}, 32'h0);
    ndr = 22'd0;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    ticks = 0;

    tick_wait(511);
    chk("restart1_state", {30'b0, est}, 32'h1);
    chk("restart1_audio", audio, 32'h0);
    tick_wait(511);
    chk("restart2_audio", audio, 32'hFF00_0000);
    tick_wait(511);
    chk("restart3_audio", audio, 32'h0200_0000);

    // left cnt reads 700 here; shortening the period must wrap on the next edge
    repeat (188) @(negedge clk);
    ndl = 22'd3;
    tick_wait(323);
    chk("shrink4_audio", audio, 32'h0300_0000);
    tick_wait(511);
    chk("shrink5_audio", audio, 32'hFC00_0000);
    tick_wait(511);
    chk("shrink6_audio", audio, 32'hFB00_0000);
    chk("shrink6_state", {30'b0, est}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
